nes_pad_responder: RTL and testbench

- Controller-side end of the NES serial pad protocol; emulates a standard 4021-style NES pad on the FPGA.
- A host (another board, or `controller_nes` looped back for self-test) drives latch and pulse.
- This block returns the 8 button bits serially on data, active-low, in order A, B, Select, Start, Up, Down, Left, Right.
- Button sources are parallel inputs: switches, bongo-derived signals, or test logic.

---
 rtl/nes_pad_responder.sv | 189 ++++++++++++++++++
 tb/tb_nes_pad_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_responder.sv
`timescale 1ns/1ps
// nes_pad_responder: emulates a 4021-style NES pad. A host drives latch_in
// and pulse_in; the block returns A,B,Select,Start,Up,Down,Left,Right
// serially on data_out, active-low.
// Host protocol: a latch high period loads the buttons, and the latch fall
// freezes them. Each pulse rising edge then advances one bit. The
// frame_done strobe marks the 8th shift.
// Optional feature: define NES_PAD_TURBO_EN to enable turbo gating of A/B.
module nes_pad_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TURBO_FRAMES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] buttons_in,
  input  logic       turbo_a_in,
  input  logic       turbo_b_in,
  input  logic       latch_in,
  input  logic       pulse_in,
  output logic       data_out,
  output logic       frame_done,
  output logic       busy
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [0:7]        shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              data_out_q, data_out_d;
  logic              frame_done_q, frame_done_d;

  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0] pulse_sync_q, pulse_sync_d;
  logic                   latch_dly_q, latch_dly_d;
  logic                   pulse_dly_q, pulse_dly_d;
  logic                   latch_rise, latch_fall, pulse_rise;

  logic [0:7] eff_buttons;

  // Synchroniser chains plus one delay flop per line for edge detection.
  always_comb begin
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], latch_in};
    pulse_sync_d = {pulse_sync_q[SYNC_STAGES-2:0], pulse_in};
    latch_dly_d  = latch_sync_q[SYNC_STAGES-1];
    pulse_dly_d  = pulse_sync_q[SYNC_STAGES-1];
  end

  assign latch_rise = latch_sync_q[SYNC_STAGES-1] & ~latch_dly_q;
  assign latch_fall = ~latch_sync_q[SYNC_STAGES-1] & latch_dly_q;
  assign pulse_rise = pulse_sync_q[SYNC_STAGES-1] & ~pulse_dly_q;

`ifdef NES_PAD_TURBO_EN
  localparam int TCNT_W = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TURBO_FRAMES - 1);

  logic [TCNT_W-1:0] turbo_cnt_q, turbo_cnt_d;
  logic              turbo_phase_q, turbo_phase_d;

  // Count completed frames; flip the turbo phase every TURBO_FRAMES of them.
  always_comb begin
    turbo_cnt_d   = turbo_cnt_q;
    turbo_phase_d = turbo_phase_q;
    if (frame_done_d) begin
      if (turbo_cnt_q == TCNT_LAST) begin
        turbo_cnt_d   = '0;
        turbo_phase_d = ~turbo_phase_q;
      end else begin
        turbo_cnt_d = turbo_cnt_q + TCNT_W'(1);
      end
    end
  end

  // Turbo counter and phase registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b1;
    end else begin
      turbo_cnt_q   <= turbo_cnt_d;
      turbo_phase_q <= turbo_phase_d;
    end
  end

  // A and B only read as pressed while the turbo phase is open.
  always_comb begin
    eff_buttons    = buttons_in;
    eff_buttons[0] = buttons_in[0] & (~turbo_a_in | turbo_phase_q);
    eff_buttons[1] = buttons_in[1] & (~turbo_b_in | turbo_phase_q);
  end
`else
  logic unused_turbo;
  assign unused_turbo = turbo_a_in ^ turbo_b_in ^ (TURBO_FRAMES == 0);
  assign eff_buttons  = buttons_in;
`endif

  // Next-state logic: load while latched, shift on pulses, abort on timeout.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_d        = tmo_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (latch_rise) begin
          state_d   = ST_LATCH;
          shift_d   = ~eff_buttons;
          bit_cnt_d = 4'd0;
        end
      end
      ST_LATCH: begin
        tmo_d     = '0;
        shift_d   = ~eff_buttons;
        bit_cnt_d = 4'd0;
        if (latch_fall) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (latch_rise) begin
          state_d   = ST_LATCH;
          shift_d   = ~eff_buttons;
          bit_cnt_d = 4'd0;
          tmo_d     = '0;
        end else if (pulse_rise) begin
          shift_d   = {shift_q[1:7], 1'b1};
          bit_cnt_d = (bit_cnt_q >= 4'd8) ? 4'd8 : bit_cnt_q + 4'd1;
          tmo_d     = '0;
          if (bit_cnt_d == 4'd8) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    data_out_d = (state_d == ST_IDLE) ? 1'b1 : shift_d[0];
  end

  // State, datapath and synchroniser registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'hFF;
      bit_cnt_q    <= 4'd0;
      tmo_q        <= '0;
      data_out_q   <= 1'b1;
      frame_done_q <= 1'b0;
      latch_sync_q <= '0;
      pulse_sync_q <= '0;
      latch_dly_q  <= 1'b0;
      pulse_dly_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
      latch_sync_q <= latch_sync_d;
      pulse_sync_q <= pulse_sync_d;
      latch_dly_q  <= latch_dly_d;
      pulse_dly_q  <= pulse_dly_d;
    end
  end

  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nes_pad_responder.sv
`timescale 1ns/1ps
// Directed bench for nes_pad_responder (TIMEOUT_CYCLES=16, TURBO_FRAMES=2).
module tb_nes_pad_responder;

  logic       clk;
  logic       rst;
  logic [0:7] buttons_in;
  logic       turbo_a_in;
  logic       turbo_b_in;
  logic       latch_in;
  logic       pulse_in;
  logic       data_out;
  logic       frame_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int fd_before;

  logic [0:7] turbo_first;

  nes_pad_responder #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16),
    .TURBO_FRAMES  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buttons_in(buttons_in),
    .turbo_a_in(turbo_a_in),
    .turbo_b_in(turbo_b_in),
    .latch_in  (latch_in),
    .pulse_in  (pulse_in),
    .data_out  (data_out),
    .frame_done(frame_done),
    .busy      (busy)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  // Count frame_done high cycles, sampled just after each rising edge
  always @(posedge clk) begin
    #2;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_once();
    pulse_in = 1'b1;
    tick(6);
    pulse_in = 1'b0;
    tick(6);
  endtask

  task automatic start_frame(input logic [0:7] b);
    buttons_in = b;
    latch_in   = 1'b1;
    tick(12);
    latch_in   = 1'b0;
    tick(6);
  endtask

  // exp[i] is the data_out level required before pulse i
  task automatic read_frame(input string tag, input logic [0:7] exp);
    for (int i = 0; i < 8; i++) begin
      check_bit($sformatf("%s_bit%0d", tag, i), data_out, exp[i]);
      pulse_once();
    end
    check_bit({tag, "_tail"}, data_out, 1'b1);
  endtask

  // Directed stimulus
  initial begin
    rst        = 1'b0;
    buttons_in = 8'b0000_0000;
    turbo_a_in = 1'b0;
    turbo_b_in = 1'b0;
    latch_in   = 1'b0;
    pulse_in   = 1'b0;

    // Reset then idle
    tick(2);
    check_bit("rst_data", data_out, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_fd", frame_done, 1'b0);
    rst = 1'b1;
    tick(10);
    check_bit("idle_data", data_out, 1'b1);
    check_bit("idle_busy", busy, 1'b0);
    check_int("idle_fd_cnt", fd_cnt, 0);

    // Full frame: A, Start, Left pressed
    buttons_in = 8'b1001_0010;
    latch_in   = 1'b1;
    tick(12);
    check_bit("latch_busy", busy, 1'b1);
    check_bit("latch_data", data_out, 1'b0);
    latch_in = 1'b0;
    tick(6);
    for (int i = 0; i < 7; i++) begin
      check_bit($sformatf("full_bit%0d", i), data_out, (8'b0110_1101 >> (7 - i)) & 1'b1);
      pulse_once();
    end
    check_bit("full_bit7", data_out, 1'b1);
    fd_before = fd_cnt;
    pulse_in  = 1'b1;
    tick(2);
    check_bit("full_fd_early", frame_done, 1'b0);
    tick(1);
    check_bit("full_fd_on", frame_done, 1'b1);
    check_bit("full_tail", data_out, 1'b1);
    check_bit("full_busy_end", busy, 1'b0);
    tick(1);
    check_bit("full_fd_off", frame_done, 1'b0);
    tick(2);
    pulse_in = 1'b0;
    tick(6);
    check_int("full_fd_count", fd_cnt - fd_before, 1);

    // Extra pulse in IDLE reads released
    pulse_once();
    check_bit("extra_data", data_out, 1'b1);
    check_bit("extra_busy", busy, 1'b0);

    // Abort on re-latch after 3 pulses
    fd_before = fd_cnt;
    start_frame(8'b1001_0010);
    pulse_once();
    pulse_once();
    pulse_once();
    start_frame(8'b1000_0000);
    check_int("abort_no_fd", fd_cnt - fd_before, 0);
    read_frame("abort", 8'b0111_1111);
    check_int("abort_fd_count", fd_cnt - fd_before, 1);

    // Timeout with no pulses
    fd_before  = fd_cnt;
    buttons_in = 8'b1000_0000;
    latch_in   = 1'b1;
    tick(12);
    latch_in   = 1'b0;
    tick(18);
    check_bit("tmo_busy_last", busy, 1'b1);
    check_bit("tmo_data_last", data_out, 1'b0);
    tick(1);
    check_bit("tmo_busy_idle", busy, 1'b0);
    check_bit("tmo_data_idle", data_out, 1'b1);
    tick(5);
    check_int("tmo_no_fd", fd_cnt - fd_before, 0);

    // Buttons change during SHIFT do not affect the frame
    start_frame(8'b1001_0010);
    buttons_in = 8'b0110_1101;
    read_frame("midchg", 8'b0110_1101);

    // Latch rise together with pulse rise, then latch fall with pulse rise
    start_frame(8'b0100_0000);
    pulse_once();
    pulse_once();
    buttons_in = 8'b1000_0001;
    latch_in   = 1'b1;
    pulse_in   = 1'b1;
    tick(4);
    check_bit("sim_rise_busy", busy, 1'b1);
    check_int("sim_rise_cnt", int'(dut.bit_cnt_q), 0);
    check_bit("sim_rise_data", data_out, 1'b0);
    pulse_in = 1'b0;
    tick(8);
    latch_in = 1'b0;
    pulse_in = 1'b1;
    tick(6);
    check_bit("sim_fall_busy", busy, 1'b1);
    check_int("sim_fall_cnt", int'(dut.bit_cnt_q), 0);
    check_bit("sim_fall_data", data_out, 1'b0);
    pulse_in = 1'b0;
    tick(6);
    fd_before = fd_cnt;
    read_frame("sim", 8'b0111_1110);
    check_int("sim_fd_count", fd_cnt - fd_before, 1);

    // Reset mid-frame
    start_frame(8'b1111_1111);
    pulse_once();
    pulse_once();
    rst = 1'b0;
    tick(1);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_data", data_out, 1'b1);
    rst = 1'b1;
    tick(4);

    // Turbo on A over 8 frames
`ifdef NES_PAD_TURBO_EN
    turbo_first = 8'b0011_0011;
`else
    turbo_first = 8'b0000_0000;
`endif
    turbo_a_in = 1'b1;
    for (int f = 0; f < 8; f++) begin
      start_frame(8'b1000_0000);
      read_frame($sformatf("turbo_f%0d", f), {turbo_first[f], 7'b111_1111});
      tick(2);
    end
    turbo_a_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
